// File: rtl/sr_excitation_gen_if.sv
// Handshake bundle between a target-word producer, the SR excitation generator and the SR flip-flop bank.
// Readback signals exist only when SR_READBACK_EN is defined.
interface sr_excitation_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] tgt;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             sr_valid;
  logic             sr_ready;
  logic [WIDTH-1:0] shadow_q;
  logic [CNT_W-1:0] toggle_cnt;
`ifdef SR_READBACK_EN
  logic [WIDTH-1:0] q_fb;
  logic             mismatch;

  modport slave (
    input  tgt, tgt_valid, sr_ready, q_fb,
    output tgt_ready, s, r, sr_valid, shadow_q, toggle_cnt, mismatch
  );
  modport master (
    output tgt, tgt_valid, sr_ready, q_fb,
    input  tgt_ready, s, r, sr_valid, shadow_q, toggle_cnt, mismatch
  );
`else
  modport slave (
    input  tgt, tgt_valid, sr_ready,
    output tgt_ready, s, r, sr_valid, shadow_q, toggle_cnt
  );
  modport master (
    output tgt, tgt_valid, sr_ready,
    input  tgt_ready, s, r, sr_valid, shadow_q, toggle_cnt
  );
`endif
endinterface

// File: rtl/sr_excitation_gen.sv
// Turns requested register words into set/reset pulses for an SR flip-flop bank and tracks the bank state.
// Define SR_READBACK_EN to add a sticky q_fb versus shadow_q comparison.
module sr_excitation_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                reset,
  sr_excitation_gen_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam int         PW      = $clog2(WIDTH + 1);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] r_reg;
  logic             sr_valid_reg;
  logic [WIDTH-1:0] tgt_latched_reg;
  logic [WIDTH-1:0] shadow_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] diff;
  logic [PW-1:0]    pop;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_diff
      assign diff[gi] = s_reg[gi] | r_reg[gi];
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + PW'(diff[i]);
    end
  end

  // Extra carry bit detects overflow so the counter sticks at all-ones.
  assign sum      = {1'b0, cnt_reg} + (CNT_W + 1)'(pop);
  assign cnt_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      s_reg           <= '0;
      r_reg           <= '0;
      sr_valid_reg    <= 1'b0;
      tgt_latched_reg <= '0;
      shadow_reg      <= '0;
      cnt_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // An unchanged word is consumed without disturbing the bank.
          if (bus.tgt_valid && (bus.tgt != shadow_reg)) begin
            s_reg           <= bus.tgt & ~shadow_reg;
            r_reg           <= ~bus.tgt & shadow_reg;
            sr_valid_reg    <= 1'b1;
            tgt_latched_reg <= bus.tgt;
            state_reg       <= DRIVE;
          end
        end
        DRIVE: begin
          if (bus.sr_ready) begin
            shadow_reg   <= tgt_latched_reg;
            cnt_reg      <= cnt_next;
            s_reg        <= '0;
            r_reg        <= '0;
            sr_valid_reg <= 1'b0;
            state_reg    <= RELEASE;
          end
        end
        RELEASE: begin
          state_reg <= IDLE;
        end
        default: begin
          s_reg        <= '0;
          r_reg        <= '0;
          sr_valid_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

`ifdef SR_READBACK_EN
  logic mismatch_reg;

  // Bank outputs have settled by RELEASE, so compare there and keep the flag until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch_reg <= 1'b0;
    end else if ((state_reg == RELEASE) && (bus.q_fb != shadow_reg)) begin
      mismatch_reg <= 1'b1;
    end
  end

  assign bus.mismatch = mismatch_reg;
`endif

  assign bus.tgt_ready  = (state_reg == IDLE);
  assign bus.s          = s_reg;
  assign bus.r          = r_reg;
  assign bus.sr_valid   = sr_valid_reg;
  assign bus.shadow_q   = shadow_reg;
  assign bus.toggle_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_excitation_gen.sv
// Directed self-checking bench for sr_excitation_gen: handshake, stall, back-to-back, reset, saturation.
module tb_sr_excitation_gen;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  sr_excitation_gen_if #(.WIDTH(8), .CNT_W(16)) bus ();

  sr_excitation_gen #(.WIDTH(8), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef SR_READBACK_EN
  logic       q_force;
  logic [7:0] q_val;
  assign bus.q_fb = q_force ? q_val : bus.shadow_q;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    bus.tgt       = '0;
    bus.tgt_valid = 1'b0;
    bus.sr_ready  = 1'b0;
    #3;
    total++; if (bus.sr_valid !== 1'b0)     begin bad++; $display("FAIL reset_sr_valid got=%b exp=0", bus.sr_valid); end
    total++; if (bus.s !== 8'h00)           begin bad++; $display("FAIL reset_s got=%h exp=00", bus.s); end
    total++; if (bus.r !== 8'h00)           begin bad++; $display("FAIL reset_r got=%h exp=00", bus.r); end
    total++; if (bus.shadow_q !== 8'h00)    begin bad++; $display("FAIL reset_shadow got=%h exp=00", bus.shadow_q); end
    total++; if (bus.toggle_cnt !== 16'h0)  begin bad++; $display("FAIL reset_cnt got=%h exp=0000", bus.toggle_cnt); end
    total++; if (bus.tgt_ready !== 1'b1)    begin bad++; $display("FAIL reset_tgt_ready got=%b exp=1", bus.tgt_ready); end
    tick();
    tick();
    reset = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_basic();
    bus.tgt = 8'hA5; bus.tgt_valid = 1'b1; bus.sr_ready = 1'b1;
    tick();
    bus.tgt_valid = 1'b0;
    total++; if (bus.s !== 8'hA5)        begin bad++; $display("FAIL basic_s got=%h exp=a5", bus.s); end
    total++; if (bus.r !== 8'h00)        begin bad++; $display("FAIL basic_r got=%h exp=00", bus.r); end
    total++; if (bus.sr_valid !== 1'b1)  begin bad++; $display("FAIL basic_sr_valid got=%b exp=1", bus.sr_valid); end
    total++; if (bus.tgt_ready !== 1'b0) begin bad++; $display("FAIL basic_tgt_ready_drive got=%b exp=0", bus.tgt_ready); end
    tick();
    total++; if (bus.shadow_q !== 8'hA5)     begin bad++; $display("FAIL basic_shadow got=%h exp=a5", bus.shadow_q); end
    total++; if (bus.toggle_cnt !== 16'd4)   begin bad++; $display("FAIL basic_cnt got=%0d exp=4", bus.toggle_cnt); end
    total++; if ((bus.s | bus.r) !== 8'h00)  begin bad++; $display("FAIL basic_release_sr got=%h/%h exp=00/00", bus.s, bus.r); end
    total++; if (bus.sr_valid !== 1'b0)      begin bad++; $display("FAIL basic_release_valid got=%b exp=0", bus.sr_valid); end
    total++; if (bus.tgt_ready !== 1'b0)     begin bad++; $display("FAIL basic_release_ready got=%b exp=0", bus.tgt_ready); end
    tick();
    total++; if (bus.tgt_ready !== 1'b1)     begin bad++; $display("FAIL basic_idle_ready got=%b exp=1", bus.tgt_ready); end
    $display("txn basic tgt=a5 shadow=%h cnt=%0d", bus.shadow_q, bus.toggle_cnt);
  endtask

  task automatic test_stall();
    bus.tgt = 8'h5A; bus.tgt_valid = 1'b1; bus.sr_ready = 1'b0;
    tick();
    bus.tgt_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.s !== 8'h5A)       begin bad++; $display("FAIL stall_s[%0d] got=%h exp=5a", i, bus.s); end
      total++; if (bus.r !== 8'hA5)       begin bad++; $display("FAIL stall_r[%0d] got=%h exp=a5", i, bus.r); end
      total++; if (bus.sr_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, bus.sr_valid); end
      total++; if (bus.toggle_cnt !== 16'd4) begin bad++; $display("FAIL stall_cnt[%0d] got=%0d exp=4", i, bus.toggle_cnt); end
      if (i == 3) bus.sr_ready = 1'b1;
      tick();
    end
    total++; if (bus.shadow_q !== 8'h5A)    begin bad++; $display("FAIL stall_shadow got=%h exp=5a", bus.shadow_q); end
    total++; if (bus.toggle_cnt !== 16'd12) begin bad++; $display("FAIL stall_cnt got=%0d exp=12", bus.toggle_cnt); end
    total++; if (bus.sr_valid !== 1'b0)     begin bad++; $display("FAIL stall_release_valid got=%b exp=0", bus.sr_valid); end
    tick();
    $display("txn stall tgt=5a shadow=%h cnt=%0d", bus.shadow_q, bus.toggle_cnt);
  endtask

  task automatic test_back_to_back();
    bus.tgt = 8'h3C; bus.tgt_valid = 1'b1; bus.sr_ready = 1'b1;
    tick();
    total++; if (bus.s !== 8'h24) begin bad++; $display("FAIL b2b_s1 got=%h exp=24", bus.s); end
    total++; if (bus.r !== 8'h42) begin bad++; $display("FAIL b2b_r1 got=%h exp=42", bus.r); end
    bus.tgt = 8'hC3;
    tick();
    total++; if (bus.shadow_q !== 8'h3C)    begin bad++; $display("FAIL b2b_shadow1 got=%h exp=3c", bus.shadow_q); end
    total++; if (bus.toggle_cnt !== 16'd16) begin bad++; $display("FAIL b2b_cnt1 got=%0d exp=16", bus.toggle_cnt); end
    total++; if (bus.tgt_ready !== 1'b0)    begin bad++; $display("FAIL b2b_release_ready got=%b exp=0", bus.tgt_ready); end
    $display("txn b2b tgt=3c shadow=%h cnt=%0d", bus.shadow_q, bus.toggle_cnt);
    tick();
    total++; if (bus.tgt_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got=%b exp=1", bus.tgt_ready); end
    total++; if (bus.sr_valid !== 1'b0)  begin bad++; $display("FAIL b2b_idle_valid got=%b exp=0", bus.sr_valid); end
    tick();
    total++; if (bus.s !== 8'hC3)       begin bad++; $display("FAIL b2b_s2 got=%h exp=c3", bus.s); end
    total++; if (bus.r !== 8'h3C)       begin bad++; $display("FAIL b2b_r2 got=%h exp=3c", bus.r); end
    total++; if (bus.sr_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid2 got=%b exp=1", bus.sr_valid); end
    bus.tgt = 8'h3C;
    tick();
    total++; if (bus.shadow_q !== 8'hC3)    begin bad++; $display("FAIL b2b_shadow2 got=%h exp=c3", bus.shadow_q); end
    total++; if (bus.toggle_cnt !== 16'd24) begin bad++; $display("FAIL b2b_cnt2 got=%0d exp=24", bus.toggle_cnt); end
    $display("txn b2b tgt=c3 shadow=%h cnt=%0d", bus.shadow_q, bus.toggle_cnt);
    tick();
    tick();
    bus.tgt_valid = 1'b0;
    total++; if (bus.s !== 8'h3C) begin bad++; $display("FAIL b2b_s3 got=%h exp=3c", bus.s); end
    total++; if (bus.r !== 8'hC3) begin bad++; $display("FAIL b2b_r3 got=%h exp=c3", bus.r); end
    tick();
    total++; if (bus.shadow_q !== 8'h3C)    begin bad++; $display("FAIL b2b_shadow3 got=%h exp=3c", bus.shadow_q); end
    total++; if (bus.toggle_cnt !== 16'd32) begin bad++; $display("FAIL b2b_cnt3 got=%0d exp=32", bus.toggle_cnt); end
    tick();
    $display("txn b2b tgt=3c shadow=%h cnt=%0d", bus.shadow_q, bus.toggle_cnt);
  endtask

  task automatic test_same_value();
    bus.tgt = 8'h3C; bus.tgt_valid = 1'b1;
    tick();
    bus.tgt_valid = 1'b0;
    total++; if (bus.sr_valid !== 1'b0)     begin bad++; $display("FAIL same_valid got=%b exp=0", bus.sr_valid); end
    total++; if (bus.tgt_ready !== 1'b1)    begin bad++; $display("FAIL same_ready got=%b exp=1", bus.tgt_ready); end
    total++; if (bus.toggle_cnt !== 16'd32) begin bad++; $display("FAIL same_cnt got=%0d exp=32", bus.toggle_cnt); end
    tick();
    total++; if (bus.sr_valid !== 1'b0)     begin bad++; $display("FAIL same_valid2 got=%b exp=0", bus.sr_valid); end
    total++; if (bus.shadow_q !== 8'h3C)    begin bad++; $display("FAIL same_shadow got=%h exp=3c", bus.shadow_q); end
    $display("txn same tgt=3c shadow=%h cnt=%0d", bus.shadow_q, bus.toggle_cnt);
  endtask

  task automatic test_reset_mid_drive();
    bus.tgt = 8'hFF; bus.tgt_valid = 1'b1; bus.sr_ready = 1'b0;
    tick();
    total++; if (bus.sr_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", bus.sr_valid); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.sr_valid !== 1'b0)    begin bad++; $display("FAIL mid_valid got=%b exp=0", bus.sr_valid); end
    total++; if (bus.s !== 8'h00)          begin bad++; $display("FAIL mid_s got=%h exp=00", bus.s); end
    total++; if (bus.r !== 8'h00)          begin bad++; $display("FAIL mid_r got=%h exp=00", bus.r); end
    total++; if (bus.shadow_q !== 8'h00)   begin bad++; $display("FAIL mid_shadow got=%h exp=00", bus.shadow_q); end
    total++; if (bus.toggle_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", bus.toggle_cnt); end
    total++; if (bus.tgt_ready !== 1'b1)   begin bad++; $display("FAIL mid_ready got=%b exp=1", bus.tgt_ready); end
    tick();
    reset = 1'b1;
    bus.tgt = 8'hA5; bus.tgt_valid = 1'b1; bus.sr_ready = 1'b1;
    tick();
    bus.tgt_valid = 1'b0;
    total++; if (bus.sr_valid !== 1'b1) begin bad++; $display("FAIL first_edge_valid got=%b exp=1", bus.sr_valid); end
    total++; if (bus.s !== 8'hA5)       begin bad++; $display("FAIL first_edge_s got=%h exp=a5", bus.s); end
    tick();
    total++; if (bus.toggle_cnt !== 16'd4) begin bad++; $display("FAIL first_edge_cnt got=%0d exp=4", bus.toggle_cnt); end
    tick();
    $display("txn reset_mid_drive shadow=%h cnt=%0d", bus.shadow_q, bus.toggle_cnt);
  endtask

  task automatic test_saturation();
    int exp_cnt;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.sr_ready = 1'b1;
    exp_cnt = 0;
    for (int k = 1; k <= 8193; k++) begin
      bus.tgt = k[0] ? 8'hFF : 8'h00;
      bus.tgt_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        total++; if ((bus.s & bus.r) !== 8'h00) begin bad++; $display("FAIL sat_s_and_r k=%0d got=%h exp=00", k, bus.s & bus.r); end
      end
      exp_cnt = (exp_cnt + 8 > 65535) ? 65535 : exp_cnt + 8;
      total++; if (bus.toggle_cnt !== exp_cnt[15:0]) begin bad++; $display("FAIL sat_cnt k=%0d got=%h exp=%h", k, bus.toggle_cnt, exp_cnt[15:0]); end
      if (k >= 8190) $display("txn sat k=%0d tgt=%h cnt=%h", k, bus.tgt, bus.toggle_cnt);
    end
    bus.tgt_valid = 1'b0;
    tick();
    total++; if (bus.toggle_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", bus.toggle_cnt); end
  endtask

`ifdef SR_READBACK_EN
  task automatic test_readback();
    q_force = 1'b0; q_val = 8'h00;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++; if (bus.mismatch !== 1'b0) begin bad++; $display("FAIL rb_reset got=%b exp=0", bus.mismatch); end
    q_force = 1'b1;
    bus.tgt = 8'h01; bus.tgt_valid = 1'b1; bus.sr_ready = 1'b1;
    tick();
    bus.tgt_valid = 1'b0;
    tick();
    total++; if (bus.mismatch !== 1'b0) begin bad++; $display("FAIL rb_before got=%b exp=0", bus.mismatch); end
    tick();
    total++; if (bus.mismatch !== 1'b1) begin bad++; $display("FAIL rb_set got=%b exp=1", bus.mismatch); end
    q_force = 1'b0;
    bus.tgt = 8'h02; bus.tgt_valid = 1'b1;
    tick();
    bus.tgt_valid = 1'b0;
    tick();
    tick();
    total++; if (bus.mismatch !== 1'b1) begin bad++; $display("FAIL rb_sticky got=%b exp=1", bus.mismatch); end
    reset = 1'b0;
    #1;
    total++; if (bus.mismatch !== 1'b0) begin bad++; $display("FAIL rb_clear got=%b exp=0", bus.mismatch); end
    tick();
    reset = 1'b1;
    $display("txn readback done");
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
`ifdef SR_READBACK_EN
    q_force = 1'b0;
    q_val   = 8'h00;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_same_value();
    test_reset_mid_drive();
    test_saturation();
`ifdef SR_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
